poli_crc_controller: RTL and testbench

Register-mapped sequencer for the POLI CRC unit. It owns the CRC_CONTROL, CRC_STATUS, CRC_INPUT and CRC_OUTPUT registers and drives a bit-serial CRC-32 engine (MSB-first, one bit per clock) through a 1-deep input holding buffer. It sits behind the control-register decode alongside the NAND/NOR and XOR/BUF units and ignores all other regsel codes.

---
 rtl/poli_crc_controller.sv | 181 ++++++++++++++++++
 tb/tb_poli_crc_controller.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/poli_crc_controller.sv
// POLI CRC controller: register-mapped sequencer around a bit-serial,
// MSB-first CRC engine with a one-word input holding buffer.
module poli_crc_controller #(
    parameter int                   WORD_SIZE = 32,
    parameter logic [WORD_SIZE-1:0] POLY      = 32'h04C11DB7,
    parameter logic [WORD_SIZE-1:0] SEED      = 32'hFFFFFFFF,
    parameter logic [WORD_SIZE-1:0] XOROUT    = 32'hFFFFFFFF
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 wen,
    input  logic                 ren,
    input  logic [3:0]           regsel,
    input  logic [WORD_SIZE-1:0] wdata,
    output logic [WORD_SIZE-1:0] rdata,
    output logic                 busy,
    output logic                 done_irq
);

    localparam int              CW       = $clog2(WORD_SIZE);
    localparam logic [CW-1:0]   LAST_BIT = CW'(WORD_SIZE - 1);

    localparam logic [3:0] SEL_CONTROL = 4'd6;
    localparam logic [3:0] SEL_STATUS  = 4'd7;
    localparam logic [3:0] SEL_INPUT   = 4'd8;
    localparam logic [3:0] SEL_OUTPUT  = 4'd9;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        SHIFT,
        FINAL,
        DONE
    } state_t;

    state_t                 state;
    logic [WORD_SIZE-1:0]   crc;
    logic [WORD_SIZE-1:0]   shift_reg;
    logic [WORD_SIZE-1:0]   hold;
    logic [WORD_SIZE-1:0]   out_reg;
    logic [CW-1:0]          cnt;
    logic                   hold_full;
    logic                   finish_pend;
    logic                   done;
    logic                   overflow;
    logic                   err;

    logic                   fb;
    logic [WORD_SIZE-1:0]   crc_nxt;
    logic                   accepting;
    logic                   drain;
    logic                   ctrl_wr;
    logic                   in_wr;
    logic [WORD_SIZE-1:0]   status;

    // Next CRC value for one serial bit, plus decode of the current cycle's
    // bus request. A hold drain this edge frees the buffer for a same-edge write.
    always_comb begin
        fb        = crc[WORD_SIZE-1] ^ shift_reg[WORD_SIZE-1];
        crc_nxt   = {crc[WORD_SIZE-2:0], 1'b0} ^ (fb ? POLY : '0);
        accepting = (state == ARMED) || (state == SHIFT);
        drain     = hold_full && ((state == ARMED) ||
                                  ((state == SHIFT) && (cnt == LAST_BIT)));
        ctrl_wr   = wen && (regsel == SEL_CONTROL);
        in_wr     = wen && (regsel == SEL_INPUT);
        status    = {{(WORD_SIZE-6){1'b0}}, finish_pend, err, overflow,
                     hold_full, done, busy};
    end

    assign busy = (state != IDLE) && (state != DONE);

    // Sequencer, register file and read port. Bus writes are applied after
    // the engine step so START/ABORT and buffer fills override it.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= IDLE;
            crc         <= '0;
            shift_reg   <= '0;
            hold        <= '0;
            out_reg     <= '0;
            cnt         <= '0;
            hold_full   <= 1'b0;
            finish_pend <= 1'b0;
            done        <= 1'b0;
            overflow    <= 1'b0;
            err         <= 1'b0;
            rdata       <= '0;
            done_irq    <= 1'b0;
        end else begin
            done_irq <= 1'b0;

            // reads sample pre-write contents
            if (ren) begin
                case (regsel)
                    SEL_CONTROL: rdata <= '0;
                    SEL_STATUS:  rdata <= status;
                    SEL_INPUT:   rdata <= hold;
                    SEL_OUTPUT:  rdata <= out_reg;
                    default:     ;
                endcase
            end

            case (state)
                ARMED: begin
                    if (hold_full) begin
                        shift_reg <= hold;
                        hold_full <= 1'b0;
                        cnt       <= '0;
                        state     <= SHIFT;
                    end else if (finish_pend) begin
                        state <= FINAL;
                    end
                end
                SHIFT: begin
                    crc       <= crc_nxt;
                    shift_reg <= {shift_reg[WORD_SIZE-2:0], 1'b0};
                    cnt       <= cnt + 1'b1;
                    if (cnt == LAST_BIT) begin
                        if (hold_full) begin
                            // back-to-back word, no bubble
                            shift_reg <= hold;
                            hold_full <= 1'b0;
                            cnt       <= '0;
                        end else begin
                            state <= ARMED;
                        end
                    end
                end
                FINAL: begin
                    out_reg     <= crc ^ XOROUT;
                    done        <= 1'b1;
                    finish_pend <= 1'b0;
                    done_irq    <= 1'b1;
                    state       <= DONE;
                end
                default: ;
            endcase

            if (in_wr) begin
                if (!accepting) begin
                    err <= 1'b1;
                end else if (hold_full && !drain) begin
                    overflow <= 1'b1;
                end else begin
                    hold      <= wdata;
                    hold_full <= 1'b1;
                end
            end

            if (ctrl_wr) begin
                if (wdata[2]) begin
                    // abort keeps out_reg so the last result stays readable
                    state       <= IDLE;
                    hold_full   <= 1'b0;
                    finish_pend <= 1'b0;
                    done        <= 1'b0;
                    overflow    <= 1'b0;
                    err         <= 1'b0;
                    done_irq    <= 1'b0;
                end else if (wdata[0]) begin
                    state       <= ARMED;
                    crc         <= SEED;
                    shift_reg   <= '0;
                    cnt         <= '0;
                    hold_full   <= 1'b0;
                    finish_pend <= wdata[1];
                    done        <= 1'b0;
                    overflow    <= 1'b0;
                    err         <= 1'b0;
                    done_irq    <= 1'b0;
                end else if (wdata[1]) begin
                    if (accepting)
                        finish_pend <= 1'b1;
                    else if ((state == IDLE) || (state == DONE))
                        err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_poli_crc_controller.sv
// Directed bench for poli_crc_controller: a default-parameter instance and
// a zero-seed/zero-xorout instance driven by the same bus.
module tb_poli_crc_controller;

    localparam logic [31:0] POLY = 32'h04C11DB7;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        wen = 1'b0;
    logic        ren = 1'b0;
    logic [3:0]  regsel = 4'd0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata0, rdata1;
    logic        busy0, busy1, irq0, irq1;

    int npass = 0;
    int ntot  = 0;
    int irq_cnt0 = 0;
    int irq_cnt1 = 0;

    poli_crc_controller u_def (
        .CLK(CLK), .RST(RST), .wen(wen), .ren(ren), .regsel(regsel),
        .wdata(wdata), .rdata(rdata0), .busy(busy0), .done_irq(irq0)
    );

    poli_crc_controller #(.SEED(32'h0), .XOROUT(32'h0)) u_zero (
        .CLK(CLK), .RST(RST), .wen(wen), .ren(ren), .regsel(regsel),
        .wdata(wdata), .rdata(rdata1), .busy(busy1), .done_irq(irq1)
    );

    always #5 CLK = ~CLK;

    // count completion pulses seen by each instance
    always @(posedge CLK) begin
        irq_cnt0 <= irq_cnt0 + (irq0 ? 1 : 0);
        irq_cnt1 <= irq_cnt1 + (irq1 ? 1 : 0);
    end

    typedef struct {
        logic        w;
        logic        r;
        logic [3:0]  sel;
        logic [31:0] wd;
        logic        chk;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[24];
    int   ntbl;

    function automatic vec_t mk(logic w, logic r, logic [3:0] sel,
                                logic [31:0] wd, logic chk, logic [31:0] exp);
        vec_t v;
        v.w = w; v.r = r; v.sel = sel; v.wd = wd; v.chk = chk; v.exp = exp;
        return v;
    endfunction

    // reference: serial MSB-first CRC of one word
    function automatic logic [31:0] crc_word(logic [31:0] c, logic [31:0] d);
        logic fbit;
        for (int b = 0; b < 32; b++) begin
            fbit = c[31] ^ d[31];
            c    = {c[30:0], 1'b0} ^ (fbit ? POLY : 32'h0);
            d    = {d[30:0], 1'b0};
        end
        return c;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic op(input logic w, input logic r, input logic [3:0] sel, input logic [31:0] d);
        wen = w; ren = r; regsel = sel; wdata = d;
        @(posedge CLK); #1;
        wen = 1'b0; ren = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge CLK); #1; end
    endtask

    // bounded wait for the completion pulse; returns edges waited
    task automatic wait_irq(output int n);
        n = 0;
        while (!irq0 && n < 300) begin tick(1); n++; end
        chk("irq_seen", {31'b0, irq0}, 32'd1);
        chk("irq_both", {31'b0, irq1}, 32'd1);
    endtask

    int n, i0, i1;
    logic [31:0] exp0, exp1, w0, w1, w2;

    initial begin
        // register-level vectors from reset
        ntbl = 0;
        tbl[ntbl++] = mk(0, 1, 4'd7, 32'h0,        1, 32'h00); // STATUS after reset
        tbl[ntbl++] = mk(0, 1, 4'd9, 32'h0,        1, 32'h00); // OUTPUT after reset
        tbl[ntbl++] = mk(1, 0, 4'd8, 32'h1234,     0, 32'h00); // INPUT in IDLE
        tbl[ntbl++] = mk(0, 1, 4'd7, 32'h0,        1, 32'h10); // err
        tbl[ntbl++] = mk(0, 1, 4'd3, 32'h0,        1, 32'h10); // foreign regsel holds
        tbl[ntbl++] = mk(0, 1, 4'd8, 32'h0,        1, 32'h00); // word was dropped
        tbl[ntbl++] = mk(1, 0, 4'd6, 32'h4,        0, 32'h00); // ABORT
        tbl[ntbl++] = mk(0, 1, 4'd7, 32'h0,        1, 32'h00); // err cleared
        tbl[ntbl++] = mk(1, 0, 4'd6, 32'h2,        0, 32'h00); // FINISH in IDLE
        tbl[ntbl++] = mk(0, 1, 4'd7, 32'h0,        1, 32'h10);
        tbl[ntbl++] = mk(0, 1, 4'd6, 32'h0,        1, 32'h00); // CONTROL reads 0
        tbl[ntbl++] = mk(1, 0, 4'd6, 32'h1,        0, 32'h00); // START
        tbl[ntbl++] = mk(0, 1, 4'd7, 32'h0,        1, 32'h01); // ARMED busy
        tbl[ntbl++] = mk(1, 0, 4'd6, 32'h2,        0, 32'h00); // FINISH
        tbl[ntbl++] = mk(0, 1, 4'd7, 32'h0,        1, 32'h21); // ARMED, pending
        tbl[ntbl++] = mk(0, 1, 4'd7, 32'h0,        1, 32'h21); // FINAL
        tbl[ntbl++] = mk(0, 1, 4'd7, 32'h0,        1, 32'h02); // DONE
        tbl[ntbl++] = mk(0, 1, 4'd9, 32'h0,        1, 32'h00); // empty CRC
        tbl[ntbl++] = mk(1, 0, 4'd6, 32'h1,        0, 32'h00); // START
        tbl[ntbl++] = mk(1, 1, 4'd8, 32'hCAFEF00D, 1, 32'h00); // rd+wr: old hold
        tbl[ntbl++] = mk(0, 1, 4'd8, 32'h0,        1, 32'hCAFEF00D);
        tbl[ntbl++] = mk(1, 0, 4'd6, 32'h4,        0, 32'h00); // ABORT

        tick(3);
        RST = 1'b0;
        tick(1);
        for (int k = 0; k < ntbl; k++) begin
            op(tbl[k].w, tbl[k].r, tbl[k].sel, tbl[k].wd);
            if (tbl[k].chk) begin
                chk($sformatf("tbl%0d_def", k), rdata0, tbl[k].exp);
                chk($sformatf("tbl%0d_zero", k), rdata1, tbl[k].exp);
            end
        end

        // single word 0x1, then 0x2
        for (int t = 1; t <= 2; t++) begin
            i0 = irq_cnt0; i1 = irq_cnt1;
            op(1, 0, 4'd6, 32'h1);
            op(1, 0, 4'd8, 32'(t));
            op(1, 0, 4'd6, 32'h2);
            wait_irq(n);
            op(0, 1, 4'd9, 32'h0);
            exp0 = crc_word(32'hFFFFFFFF, 32'(t)) ^ 32'hFFFFFFFF;
            exp1 = (t == 1) ? 32'h04C11DB7 : 32'h09823B6E;
            chk("word_def", rdata0, exp0);
            chk("word_zero", rdata1, exp1);
            tick(3);
            chk("irq_once_def", 32'(irq_cnt0 - i0), 32'd1);
            chk("irq_once_zero", 32'(irq_cnt1 - i1), 32'd1);
        end

        // empty message: START+FINISH, done on the 2nd edge after the write
        op(1, 0, 4'd6, 32'h3);
        chk("empty_e0_irq", {31'b0, irq0}, 32'd0);
        tick(1);
        chk("empty_e1_irq", {31'b0, irq0}, 32'd0);
        chk("empty_e1_busy", {31'b0, busy0}, 32'd1);
        tick(1);
        chk("empty_e2_irq", {31'b0, irq0}, 32'd1);
        chk("empty_e2_busy", {31'b0, busy0}, 32'd0);
        op(0, 1, 4'd9, 32'h0);
        chk("empty_out", rdata0, 32'h0);

        // back-to-back words, then a 4th word into a full buffer
        w0 = 32'h12345678; w1 = 32'h9ABCDEF0; w2 = 32'h0F1E2D3C;
        op(1, 0, 4'd6, 32'h1);
        op(1, 0, 4'd8, w0);                  // edge k
        tick(19);
        op(1, 0, 4'd8, w1);                  // k+20
        tick(19);
        op(1, 0, 4'd8, w2);                  // k+40
        tick(4);
        op(0, 1, 4'd7, 32'h0);               // k+45
        chk("b2b_no_ovf", rdata0, 32'h05);
        tick(4);
        op(1, 0, 4'd8, 32'hDEADDEAD);        // k+50, dropped
        op(0, 1, 4'd7, 32'h0);               // k+51
        chk("b2b_ovf", rdata0, 32'h0D);
        op(1, 0, 4'd6, 32'h2);               // k+52
        wait_irq(n);
        chk("b2b_latency", 32'(n + 52), 32'd99);
        op(0, 1, 4'd9, 32'h0);
        exp0 = crc_word(crc_word(crc_word(32'hFFFFFFFF, w0), w1), w2) ^ 32'hFFFFFFFF;
        exp1 = crc_word(crc_word(crc_word(32'h0, w0), w1), w2);
        chk("b2b_def", rdata0, exp0);
        chk("b2b_zero", rdata1, exp1);
        op(0, 1, 4'd7, 32'h0);
        chk("b2b_status", rdata0, 32'h0A);

        // write lands on the edge the hold reg drains into the shifter
        op(1, 0, 4'd6, 32'h1);
        op(1, 0, 4'd8, w2);                  // edge k
        tick(4);
        op(1, 0, 4'd8, w1);                  // k+5
        tick(27);
        op(1, 0, 4'd8, w0);                  // k+33, drain edge
        op(0, 1, 4'd7, 32'h0);
        chk("drain_status", rdata0, 32'h05);
        op(1, 0, 4'd6, 32'h2);
        wait_irq(n);
        op(0, 1, 4'd9, 32'h0);
        exp0 = crc_word(crc_word(crc_word(32'hFFFFFFFF, w2), w1), w0) ^ 32'hFFFFFFFF;
        chk("drain_def", rdata0, exp0);
        exp1 = rdata0;

        // abort mid-shift keeps OUTPUT, then a clean single-word run
        op(1, 0, 4'd6, 32'h1);
        op(1, 0, 4'd8, 32'hA5A5A5A5);
        tick(10);
        op(1, 0, 4'd6, 32'h4);
        op(0, 1, 4'd9, 32'h0);
        chk("abort_keeps_out", rdata0, exp0);
        op(0, 1, 4'd7, 32'h0);
        chk("abort_status", rdata0, 32'h0);
        op(1, 0, 4'd6, 32'h1);
        op(1, 0, 4'd8, 32'h00000001);
        op(1, 0, 4'd6, 32'h2);
        wait_irq(n);
        op(0, 1, 4'd9, 32'h0);
        chk("abort_rerun_zero", rdata1, 32'h04C11DB7);
        chk("abort_rerun_def", rdata0, crc_word(32'hFFFFFFFF, 32'h1) ^ 32'hFFFFFFFF);

        // FINISH with nothing running: error flag, no completion pulse
        op(1, 0, 4'd6, 32'h4);
        i0 = irq_cnt0;
        op(1, 0, 4'd6, 32'h2);
        tick(5);
        chk("idle_finish_noirq", 32'(irq_cnt0 - i0), 32'd0);
        op(0, 1, 4'd7, 32'h0);
        chk("idle_finish_err", rdata0, 32'h10);

        // asynchronous reset in the middle of a word
        op(1, 0, 4'd6, 32'h1);
        op(1, 0, 4'd8, 32'h13579BDF);
        tick(10);
        chk("pre_rst_busy", {31'b0, busy0}, 32'd1);
        #3 RST = 1'b1;
        #1;
        chk("rst_busy", {31'b0, busy0}, 32'd0);
        chk("rst_irq", {31'b0, irq0}, 32'd0);
        chk("rst_rdata", rdata0, 32'h0);
        @(posedge CLK); #1;
        RST = 1'b0;
        op(0, 1, 4'd7, 32'h0);
        chk("rst_status", rdata0, 32'h0);
        op(0, 1, 4'd9, 32'h0);
        chk("rst_out", rdata0, 32'h0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
